// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search engine.
package sar_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_TRIAL = 1'b1
  } state_e;

  // Bit-index width for an N-bit operand; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sar_search_if.sv
// Comparator-facing bus of the search engine: trial out, flags back, result/status out.
interface sar_search_if #(
  parameter int unsigned N = 3
);
  logic         start;
  logic [N-1:0] trial;
  logic         flag_eq;
  logic         flag_gr;
  logic         flag_lr;
  logic [N-1:0] result;
  logic         busy;
  logic         done;
  logic         err;

  modport master (
    input  start, flag_eq, flag_gr, flag_lr,
    output trial, result, busy, done, err
  );

  modport slave (
    output start, flag_eq, flag_gr, flag_lr,
    input  trial, result, busy, done, err
  );
endinterface

// File: rtl/sar_search.sv
// MSB-first binary search of an operand visible only through a comparator;
// one trial per cycle, early exit on equality, sticky err on a bad flag set.
module sar_search
  import sar_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic        clock,
  input  logic        reset_,
  sar_search_if.master bus
);

  localparam int unsigned KW = idx_width(N);

  state_e         state_q, state_d;
  logic [N-1:0]   trial_q, trial_d;
  logic [N-1:0]   result_q, result_d;
  logic [KW-1:0]  k_q, k_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic [N-1:0]   bit_k_c;
  logic [N-1:0]   kept_c;
  logic [N-1:0]   next_trial_c;
  logic [2:0]     flags_c;

  // Keep or clear bit k, then arm bit k-1 for the next trial.
  always_comb begin
    bit_k_c      = N'(1) << k_q;
    kept_c       = bus.flag_lr ? (trial_q & ~bit_k_c) : trial_q;
    next_trial_c = kept_c | (bit_k_c >> 1);
    flags_c      = {bus.flag_eq, bus.flag_gr, bus.flag_lr};
  end

  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    result_d = result_q;
    k_d      = k_q;
    done_d   = 1'b0;
    err_d    = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          trial_d = N'(1) << (N - 1);
          k_d     = KW'(N - 1);
          err_d   = 1'b0;
          state_d = S_TRIAL;
        end
      end
      S_TRIAL: begin
        unique case (flags_c)
          3'b100: begin
            result_d = trial_q;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end
          3'b010, 3'b001: begin
            if (k_q != '0) begin
              trial_d = next_trial_c;
              k_d     = k_q - KW'(1);
            end else begin
              trial_d  = kept_c;
              result_d = kept_c;
              done_d   = 1'b1;
              state_d  = S_IDLE;
            end
          end
          default: begin
            // Comparator broke the one-hot contract: abandon the search.
            err_d   = 1'b1;
            trial_d = '0;
            state_d = S_IDLE;
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q  <= S_IDLE;
      trial_q  <= '0;
      result_q <= '0;
      k_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      k_q      <= k_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.trial  = trial_q;
  assign bus.result = result_q;
  assign bus.busy   = (state_q == S_TRIAL);
  assign bus.done   = done_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench: behavioural comparator with flag override, arithmetic search model.
module tb_sar_search;

  localparam int unsigned N = 3;

  logic         clock;
  logic         reset_;
  logic [N-1:0] cur_x;
  logic         fault;
  logic [2:0]   fault_flags;
  int           total;
  int           bad;

  sar_search_if #(.N(N)) bus ();

  sar_search #(.N(N)) dut (
    .clock (clock),
    .reset_(reset_),
    .bus   (bus)
  );

  assign bus.flag_eq = fault ? fault_flags[2] : (cur_x == bus.trial);
  assign bus.flag_gr = fault ? fault_flags[1] : (cur_x >  bus.trial);
  assign bus.flag_lr = fault ? fault_flags[0] : (cur_x <  bus.trial);

  always #5 clock = ~clock;

  // Trial i of an ideal search: the top i-1 bits of x followed by a single probe bit.
  function automatic int model_trial(input int xv, input int i);
    int sh;
    sh = N - i + 1;
    return ((xv >> sh) << sh) | (1 << (N - i));
  endfunction

  function automatic int model_count(input int xv);
    for (int i = 1; i <= N; i++)
      if (model_trial(xv, i) == xv) return i;
    return N;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Entered just after a negedge with the DUT idle; returns in the done cycle.
  task automatic search(input int xv, input bit poke);
    int tt;
    tt    = model_count(xv);
    cur_x = N'(xv);
    bus.start = 1'b1;
    @(negedge clock);
    for (int i = 1; i <= tt; i++) begin
      bus.start = poke && (i < tt);
      chk("trial", bus.trial, model_trial(xv, i));
      chk("busy_in_trial", bus.busy, 1);
      chk("done_in_trial", bus.done, 0);
      if (i == 1) chk("err_cleared", bus.err, 0);
      @(negedge clock);
    end
    bus.start = 1'b0;
    chk("done_pulse", bus.done, 1);
    chk("busy_at_done", bus.busy, 0);
    chk("result", bus.result, xv);
    chk("err_at_done", bus.err, 0);
  endtask

  task automatic idle_gap(input int xv);
    @(negedge clock);
    chk("done_one_cycle", bus.done, 0);
    chk("busy_idle", bus.busy, 0);
    chk("result_held", bus.result, xv);
  endtask

  initial begin
    int rx;
    clock = 1'b0;
    reset_ = 1'b0;
    bus.start = 1'b0;
    cur_x = '0;
    fault = 1'b0;
    fault_flags = 3'b000;
    total = 0;
    bad = 0;

    repeat (2) @(negedge clock);
    chk("rst_trial", bus.trial, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    reset_ = 1'b1;
    @(negedge clock);

    search(5, 1'b0); idle_gap(5);
    search(0, 1'b0); idle_gap(0);
    search(4, 1'b0); idle_gap(4);
    search(7, 1'b0);
    search(2, 1'b0); idle_gap(2);

    // Empty flag response on the first trial.
    search(3, 1'b0); idle_gap(3);
    fault = 1'b1;
    fault_flags = 3'b000;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    chk("fault_busy_t1", bus.busy, 1);
    @(negedge clock);
    chk("fault_err", bus.err, 1);
    chk("fault_done", bus.done, 0);
    chk("fault_busy", bus.busy, 0);
    chk("fault_result", bus.result, 3);
    chk("fault_trial", bus.trial, 0);
    fault = 1'b0;
    @(negedge clock);
    chk("err_sticky", bus.err, 1);
    search(6, 1'b0); idle_gap(6);

    // Multi-flag response mid-search.
    cur_x = 3'd1;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    fault = 1'b1;
    fault_flags = 3'b011;
    @(negedge clock);
    chk("multi_err", bus.err, 1);
    chk("multi_done", bus.done, 0);
    chk("multi_result", bus.result, 6);
    fault = 1'b0;

    // Reset during the second trial of x=6.
    cur_x = 3'd6;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    chk("pre_rst_trial2", bus.trial, 6);
    reset_ = 1'b0;
    @(negedge clock);
    chk("mid_rst_trial", bus.trial, 0);
    chk("mid_rst_result", bus.result, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_err", bus.err, 0);
    reset_ = 1'b1;
    @(negedge clock);
    chk("post_rst_idle", bus.busy, 0);

    // start held during TRIAL must not disturb or queue a search.
    search(1, 1'b1); idle_gap(1);

    for (int n = 0; n < 24; n++) begin
      rx = int'($urandom_range(0, (1 << N) - 1));
      search(rx, n[0]);
      if ($urandom_range(0, 1) == 0) idle_gap(rx);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
